spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on this clock (rising and falling edges).
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: transfer request, sampled on rising clk.
REQ-004 SHALL have port slaveSelect, input, 2 bits: target slave index, 0..2; 3 means no slave.
REQ-005 SHALL have port masterDataToSend, input, 8 bits: byte to transmit, captured at start.
REQ-006 SHALL have port masterDataReceived, output, 8 bits: last byte received from the slave.
REQ-007 SHALL have port SCLK, output, 1 bit: serial clock to the slaves.
REQ-008 SHALL have port CS, output, 3 bits: active-low chip selects, bit n for slave n.
REQ-009 SHALL have port MOSI, output, 1 bit: serial data out (master to slave).
REQ-010 SHALL have port MISO, input, 1 bit: serial data in (slave to master).

Function
REQ-011 SHALL implement FSM states IDLE, TRANSFER, DONE.
REQ-012 In IDLE, on a rising clk edge with start=1 and slaveSelect<3, SHALL:
- latch masterDataToSend and slaveSelect;
- drive MOSI with data bit 0 (LSB);
- clear the bit counter;
- enter TRANSFER.
REQ-013 start with slaveSelect=3 SHALL be ignored; the FSM stays in IDLE.
REQ-014 Data SHALL be shifted LSB first in both directions; bit k is the bit of numeric weight 2^k.
REQ-015 In TRANSFER, each falling clk edge SHALL sample MISO into received bit k (k = 0..7, in order).
REQ-016 In TRANSFER, each rising clk edge after the load edge SHALL drive MOSI with the next transmit bit (1..7).
REQ-017 Transmit bit k SHALL be stable on MOSI during the falling edge on which received bit k is sampled.
REQ-018 After the 8th falling-edge sample, the next rising edge SHALL:
- copy the received byte to masterDataReceived;
- deassert CS;
- enter DONE.
REQ-019 DONE SHALL return to IDLE on the next rising edge.
REQ-020 Total latency from the start-sampling edge to the masterDataReceived update SHALL be 8 clk periods.
REQ-021 CS bit for the latched slave SHALL be 0 from the start-sampling edge until the end of TRANSFER; all other CS bits SHALL be 1.
REQ-022 While no transfer is active, CS SHALL be 3'b111.
REQ-023 SHALL drive SCLK = ~clk while in TRANSFER (SCLK rises at each MISO sampling edge) and 0 otherwise.
REQ-024 start asserted during TRANSFER or DONE SHALL be ignored; changes to masterDataToSend or slaveSelect during a transfer SHALL have no effect.
REQ-025 SHALL hold masterDataReceived between transfers; it changes only per REQ-018.
REQ-026 Holding start=1 continuously SHALL start a new transfer from IDLE each time the FSM returns to IDLE.
REQ-027 MOSI SHALL be 0 when idle.

Reset
REQ-028 reset=0 SHALL asynchronously force:
- FSM to IDLE, counter to 0;
- masterDataReceived = 8'h00;
- CS = 3'b111, SCLK = 0, MOSI = 0.
REQ-029 reset asserted mid-transfer SHALL abort the transfer; masterDataReceived stays 0 and no partial byte is published.
REQ-030 After reset is released, the first start SHALL behave per REQ-012.

Verification
REQ-031 The bench SHALL cover:
- Send 8'b01010011, slave drives 8'b01111111 LSB first on rising clk -> bench captures 8'b01010011 from MOSI on falling clk; masterDataReceived=8'b01111111.
- Back-to-back pairs 00100010/10000011, 00111100/10011000, 00100101/11000010 (send/slave), 20 periods apart -> all 8 checks pass.
- slaveSelect=1 -> CS=3'b101 during TRANSFER, 3'b111 otherwise; SCLK toggles exactly 8 times (8 rising edges).
- slaveSelect=3 with start=1 -> CS stays 111, SCLK stays 0, masterDataReceived unchanged.
- reset low after 4 bits -> CS=111, SCLK=0, MOSI=0, masterDataReceived=0 immediately; a new transfer of 8'hA5/8'h3C then completes correctly.
- start pulsed again mid-transfer -> ignored; byte completes in 8 periods.

Source files
------------

// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: host-side request/response plus the serial SPI pins.
interface spi_master_if;
  logic       start;
  logic [1:0] slaveSelect;
  logic [7:0] masterDataToSend;
  logic [7:0] masterDataReceived;
  logic       SCLK;
  logic [2:0] CS;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, slaveSelect, masterDataToSend, MISO,
    output masterDataReceived, SCLK, CS, MOSI
  );

  modport slave (
    output start, slaveSelect, masterDataToSend, MISO,
    input  masterDataReceived, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI master: LSB first, MOSI launched on rising clk, MISO sampled on falling clk.
module spi_master (
  input  logic        clk,
  input  logic        reset,
  spi_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, TRANSFER, DONE} state_t;

  state_t     state, nextState;
  logic [7:0] txData;
  logic [7:0] rxShift;
  logic [1:0] selLatch;
  logic [3:0] bitCnt;
  logic       startOk;
  logic       lastBit;

  assign startOk = bus.start && (bus.slaveSelect != 2'd3);
  assign lastBit = (bitCnt == 4'd8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (startOk) nextState = TRANSFER;
      TRANSFER: if (lastBit) nextState = DONE;
      DONE:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Rising edge: load request, launch transmit bits, publish the received byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txData                 <= 8'h00;
      selLatch               <= 2'd0;
      bus.MOSI               <= 1'b0;
      bus.masterDataReceived <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (startOk) begin
            txData   <= bus.masterDataToSend;
            selLatch <= bus.slaveSelect;
            bus.MOSI <= bus.masterDataToSend[0];
          end else begin
            bus.MOSI <= 1'b0;
          end
        end
        TRANSFER: begin
          if (lastBit) begin
            bus.masterDataReceived <= rxShift;
            bus.MOSI               <= 1'b0;
          end else begin
            // bitCnt already counts the samples taken, so it indexes the next bit to launch
            bus.MOSI <= txData[bitCnt[2:0]];
          end
        end
        default: bus.MOSI <= 1'b0;
      endcase
    end
  end

  // Falling edge: sample MISO; the counter parks at zero outside TRANSFER so each load starts clean.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bitCnt  <= 4'd0;
      rxShift <= 8'h00;
    end else if (state == TRANSFER) begin
      if (!lastBit) begin
        rxShift[bitCnt[2:0]] <= bus.MISO;
        bitCnt               <= bitCnt + 4'd1;
      end
    end else begin
      bitCnt <= 4'd0;
    end
  end

  always_comb begin
    bus.CS = 3'b111;
    if (state == TRANSFER) bus.CS[selLatch] = 1'b0;
  end

  assign bus.SCLK = (state == TRANSFER) & ~clk;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a bench-side slave drives MISO on rising clk and captures MOSI on falling clk.
module tb_spi_master;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   sclkRises;

  spi_master_if bus ();

  spi_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge bus.SCLK) sclkRises++;

  // One transfer from the slave side. Returns captured MOSI byte, masterDataReceived just
  // before the publishing edge, CS mismatches seen during the 8 bits and SCLK rise count.
  task automatic doXfer(input logic [7:0] send, input logic [7:0] slv, input logic [1:0] sel,
                        input bit midStart, input bit holdStart,
                        output logic [7:0] cap, output logic [7:0] mdrPre,
                        output int csErr, output int rises);
    logic [2:0] expCs;
    expCs      = 3'b111;
    expCs[sel] = 1'b0;
    csErr      = 0;
    cap        = 8'h00;
    mdrPre     = 8'h00;
    @(negedge clk);
    bus.masterDataToSend = send;
    bus.slaveSelect      = sel;
    bus.start            = 1'b1;
    bus.MISO             = slv[0];
    sclkRises            = 0;
    @(posedge clk);
    #1;
    if (!holdStart) bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cap[k] = bus.MOSI;
      if (bus.CS !== expCs) csErr++;
      if (k == 7) mdrPre = bus.masterDataReceived;
      @(posedge clk);
      #1;
      if (k < 7) bus.MISO = slv[k+1];
      if (midStart && k == 3) begin
        bus.start            = 1'b1;
        bus.masterDataToSend = ~send;
        bus.slaveSelect      = 2'd2;
      end
      if (midStart && k == 4) begin
        bus.start            = 1'b0;
        bus.masterDataToSend = send;
        bus.slaveSelect      = sel;
      end
    end
    rises = sclkRises;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL reset_cs got=%b want=111", bus.CS); end
    checks++; if (bus.SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b want=0", bus.SCLK); end
    checks++; if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b want=0", bus.MOSI); end
    checks++; if (bus.masterDataReceived !== 8'h00) begin errors++; $display("FAIL reset_mdr got=%h want=00", bus.masterDataReceived); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] cap, pre; int csErr, rises;
    doXfer(8'b01010011, 8'b01111111, 2'd0, 1'b0, 1'b0, cap, pre, csErr, rises);
    checks++; if (cap !== 8'b01010011) begin errors++; $display("FAIL basic_mosi got=%b want=01010011", cap); end
    checks++; if (bus.masterDataReceived !== 8'b01111111) begin errors++; $display("FAIL basic_mdr got=%b want=01111111", bus.masterDataReceived); end
    checks++; if (pre !== 8'h00) begin errors++; $display("FAIL basic_latency got=%h want=00 before publish edge", pre); end
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL basic_cs_end got=%b want=111", bus.CS); end
    @(posedge clk); #1;
    checks++; if (bus.masterDataReceived !== 8'b01111111) begin errors++; $display("FAIL basic_hold got=%b want=01111111", bus.masterDataReceived); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] sendV [3] = '{8'b00100010, 8'b00111100, 8'b00100101};
    logic [7:0] slvV  [3] = '{8'b10000011, 8'b10011000, 8'b11000010};
    logic [7:0] cap, pre; int csErr, rises;
    for (int i = 0; i < 3; i++) begin
      doXfer(sendV[i], slvV[i], 2'd2, 1'b0, 1'b0, cap, pre, csErr, rises);
      checks++; if (cap !== sendV[i]) begin errors++; $display("FAIL b2b_mosi[%0d] got=%b want=%b", i, cap, sendV[i]); end
      checks++; if (bus.masterDataReceived !== slvV[i]) begin errors++; $display("FAIL b2b_mdr[%0d] got=%b want=%b", i, bus.masterDataReceived, slvV[i]); end
      repeat (11) @(posedge clk);
    end
  endtask

  task automatic test_cs_sel1;
    logic [7:0] cap, pre; int csErr, rises;
    doXfer(8'hC3, 8'h5A, 2'd1, 1'b0, 1'b0, cap, pre, csErr, rises);
    checks++; if (csErr !== 0) begin errors++; $display("FAIL sel1_cs_during bad_samples=%0d want=0 (CS=101)", csErr); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL sel1_sclk_rises got=%0d want=8", rises); end
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL sel1_cs_after got=%b want=111", bus.CS); end
    checks++; if (bus.masterDataReceived !== 8'h5A) begin errors++; $display("FAIL sel1_mdr got=%h want=5a", bus.masterDataReceived); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_no_slave;
    int bad = 0;
    @(negedge clk);
    sclkRises            = 0;
    bus.slaveSelect      = 2'd3;
    bus.masterDataToSend = 8'hFF;
    bus.start            = 1'b1;
    bus.MISO             = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.CS !== 3'b111 || bus.SCLK !== 1'b0 || bus.MOSI !== 1'b0) bad++;
    end
    bus.start = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL noslave_pins bad_cycles=%0d want=0", bad); end
    checks++; if (sclkRises !== 0) begin errors++; $display("FAIL noslave_sclk got=%0d want=0", sclkRises); end
    checks++; if (bus.masterDataReceived !== 8'h5A) begin errors++; $display("FAIL noslave_mdr got=%h want=5a", bus.masterDataReceived); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] cap, pre; int csErr, rises;
    @(negedge clk);
    bus.masterDataToSend = 8'hFF;
    bus.slaveSelect      = 2'd0;
    bus.start            = 1'b1;
    bus.MISO             = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL rstmid_cs got=%b want=111", bus.CS); end
    checks++; if (bus.SCLK !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got=%b want=0", bus.SCLK); end
    checks++; if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL rstmid_mosi got=%b want=0", bus.MOSI); end
    checks++; if (bus.masterDataReceived !== 8'h00) begin errors++; $display("FAIL rstmid_mdr got=%h want=00", bus.masterDataReceived); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (bus.masterDataReceived !== 8'h00) begin errors++; $display("FAIL rstmid_nopartial got=%h want=00", bus.masterDataReceived); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    doXfer(8'hA5, 8'h3C, 2'd0, 1'b0, 1'b0, cap, pre, csErr, rises);
    checks++; if (cap !== 8'hA5) begin errors++; $display("FAIL rstmid_new_mosi got=%h want=a5", cap); end
    checks++; if (bus.masterDataReceived !== 8'h3C) begin errors++; $display("FAIL rstmid_new_mdr got=%h want=3c", bus.masterDataReceived); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_start_mid;
    logic [7:0] cap, pre; int csErr, rises;
    doXfer(8'h96, 8'hE1, 2'd0, 1'b1, 1'b0, cap, pre, csErr, rises);
    checks++; if (cap !== 8'h96) begin errors++; $display("FAIL midstart_mosi got=%h want=96", cap); end
    checks++; if (csErr !== 0) begin errors++; $display("FAIL midstart_cs bad_samples=%0d want=0", csErr); end
    checks++; if (pre !== 8'h3C) begin errors++; $display("FAIL midstart_latency got=%h want=3c before publish edge", pre); end
    checks++; if (bus.masterDataReceived !== 8'hE1) begin errors++; $display("FAIL midstart_mdr got=%h want=e1", bus.masterDataReceived); end
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL midstart_no_restart got=%b want=111", bus.CS); end
  endtask

  task automatic test_hold_start;
    logic [7:0] cap, pre; int csErr, rises;
    doXfer(8'h0F, 8'h81, 2'd1, 1'b0, 1'b1, cap, pre, csErr, rises);
    checks++; if (bus.masterDataReceived !== 8'h81) begin errors++; $display("FAIL hold_first_mdr got=%h want=81", bus.masterDataReceived); end
    bus.MISO = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.CS !== 3'b111) begin errors++; $display("FAIL hold_idle_cs got=%b want=111", bus.CS); end
    @(posedge clk); #1;
    checks++; if (bus.CS !== 3'b101) begin errors++; $display("FAIL hold_restart_cs got=%b want=101", bus.CS); end
    bus.start = 1'b0;
    repeat (10) @(posedge clk); #1;
    checks++; if (bus.masterDataReceived !== 8'hFF) begin errors++; $display("FAIL hold_second_mdr got=%h want=ff", bus.masterDataReceived); end
  endtask

  initial begin
    errors               = 0;
    checks               = 0;
    sclkRises            = 0;
    reset                = 1'b0;
    bus.start            = 1'b0;
    bus.slaveSelect      = 2'd3;
    bus.masterDataToSend = 8'h00;
    bus.MISO             = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_cs_sel1();
    test_no_slave();
    test_reset_mid();
    test_start_mid();
    test_hold_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
